// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU control encodings, forwarding select codes and datapath defaults.
package cpu_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int AW_DEFAULT = 5;
  localparam int CW_DEFAULT = 4;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/fwd_unit.sv
// Per-operand forwarding source select: EX/MEM beats MEM/WB beats the registered value.
module fwd_unit
  import cpu_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic [AW-1:0] src_addr_i,
  input  logic          exmem_reg_write_i,
  input  logic [AW-1:0] exmem_rd_addr_i,
  input  logic          memwb_reg_write_i,
  input  logic [AW-1:0] memwb_rd_addr_i,
  output fwd_sel_e      sel_o
);

  // $0 is hardwired, so a writer targeting it must never be forwarded.
  always_comb begin
    sel_o = FWD_REG;
    if (exmem_reg_write_i && (exmem_rd_addr_i != '0) && (exmem_rd_addr_i == src_addr_i)) begin
      sel_o = FWD_EXMEM;
    end else if (memwb_reg_write_i && (memwb_rd_addr_i != '0) &&
                 (memwb_rd_addr_i == src_addr_i)) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with operand forwarding and load-use detection.
// Build option: define ID_EX_FWD_EN to enable forwarding; otherwise RAW hazards stall instead.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic          id_valid_i,
  input  logic [DW-1:0] id_rs_data_i,
  input  logic [DW-1:0] id_rt_data_i,
  input  logic [DW-1:0] id_imm_i,
  input  logic [AW-1:0] id_rs_addr_i,
  input  logic [AW-1:0] id_rt_addr_i,
  input  logic [AW-1:0] id_rd_addr_i,
  input  logic [CW-1:0] id_alu_ctrl_i,
  input  logic          id_alu_src_i,
  input  logic          id_reg_dst_i,
  input  logic          id_reg_write_i,
  input  logic          id_mem_read_i,
  input  logic          exmem_reg_write_i,
  input  logic [AW-1:0] exmem_rd_addr_i,
  input  logic [DW-1:0] exmem_result_i,
  input  logic          memwb_reg_write_i,
  input  logic [AW-1:0] memwb_rd_addr_i,
  input  logic [DW-1:0] memwb_data_i,
  output logic          ex_valid_o,
  output logic [DW-1:0] alu_src1_o,
  output logic [DW-1:0] alu_src2_o,
  output logic [CW-1:0] alu_ctrl_o,
  output logic [DW-1:0] ex_store_data_o,
  output logic [AW-1:0] ex_dst_addr_o,
  output logic          ex_reg_write_o,
  output logic          ex_mem_read_o,
  output logic          hazard_o
);

  logic          valid_q,     valid_d;
  logic [DW-1:0] rs_data_q,   rs_data_d;
  logic [DW-1:0] rt_data_q,   rt_data_d;
  logic [DW-1:0] imm_q,       imm_d;
  logic [AW-1:0] rs_addr_q,   rs_addr_d;
  logic [AW-1:0] rt_addr_q,   rt_addr_d;
  logic [AW-1:0] rd_addr_q,   rd_addr_d;
  logic [CW-1:0] alu_ctrl_q,  alu_ctrl_d;
  logic          alu_src_q,   alu_src_d;
  logic          reg_dst_q,   reg_dst_d;
  logic          reg_write_q, reg_write_d;
  logic          mem_read_q,  mem_read_d;

  always_comb begin
    valid_d     = valid_q;
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    imm_d       = imm_q;
    rs_addr_d   = rs_addr_q;
    rt_addr_d   = rt_addr_q;
    rd_addr_d   = rd_addr_q;
    alu_ctrl_d  = alu_ctrl_q;
    alu_src_d   = alu_src_q;
    reg_dst_d   = reg_dst_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    if (flush_i) begin
      // Bubble clears data fields too so a flushed slot is fully deterministic.
      valid_d     = 1'b0;
      rs_data_d   = '0;
      rt_data_d   = '0;
      imm_d       = '0;
      rs_addr_d   = '0;
      rt_addr_d   = '0;
      rd_addr_d   = '0;
      alu_ctrl_d  = '0;
      alu_src_d   = 1'b0;
      reg_dst_d   = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
    end else if (!stall_i) begin
      valid_d     = id_valid_i;
      rs_data_d   = id_rs_data_i;
      rt_data_d   = id_rt_data_i;
      imm_d       = id_imm_i;
      rs_addr_d   = id_rs_addr_i;
      rt_addr_d   = id_rt_addr_i;
      rd_addr_d   = id_rd_addr_i;
      alu_ctrl_d  = id_alu_ctrl_i;
      alu_src_d   = id_alu_src_i;
      reg_dst_d   = id_reg_dst_i;
      reg_write_d = id_reg_write_i;
      mem_read_d  = id_mem_read_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q     <= 1'b0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rd_addr_q   <= '0;
      alu_ctrl_q  <= '0;
      alu_src_q   <= 1'b0;
      reg_dst_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      rs_addr_q   <= rs_addr_d;
      rt_addr_q   <= rt_addr_d;
      rd_addr_q   <= rd_addr_d;
      alu_ctrl_q  <= alu_ctrl_d;
      alu_src_q   <= alu_src_d;
      reg_dst_q   <= reg_dst_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
    end
  end

  logic [AW-1:0] dst_addr;
  logic [DW-1:0] opa, opb;
  logic          load_use;

  assign dst_addr = reg_dst_q ? rd_addr_q : rt_addr_q;
  assign load_use = valid_q && mem_read_q && (dst_addr != '0) && id_valid_i &&
                    ((dst_addr == id_rs_addr_i) || ((dst_addr == id_rt_addr_i) && !id_alu_src_i));

`ifdef ID_EX_FWD_EN
  fwd_sel_e sel_a, sel_b;

  fwd_unit #(.AW(AW)) u_fwd_a (
    .src_addr_i        (rs_addr_q),
    .exmem_reg_write_i (exmem_reg_write_i),
    .exmem_rd_addr_i   (exmem_rd_addr_i),
    .memwb_reg_write_i (memwb_reg_write_i),
    .memwb_rd_addr_i   (memwb_rd_addr_i),
    .sel_o             (sel_a)
  );

  fwd_unit #(.AW(AW)) u_fwd_b (
    .src_addr_i        (rt_addr_q),
    .exmem_reg_write_i (exmem_reg_write_i),
    .exmem_rd_addr_i   (exmem_rd_addr_i),
    .memwb_reg_write_i (memwb_reg_write_i),
    .memwb_rd_addr_i   (memwb_rd_addr_i),
    .sel_o             (sel_b)
  );

  always_comb begin
    opa = rs_data_q;
    opb = rt_data_q;
    case (sel_a)
      FWD_EXMEM: opa = exmem_result_i;
      FWD_MEMWB: opa = memwb_data_i;
      default:   opa = rs_data_q;
    endcase
    case (sel_b)
      FWD_EXMEM: opb = exmem_result_i;
      FWD_MEMWB: opb = memwb_data_i;
      default:   opb = rt_data_q;
    endcase
  end

  assign hazard_o = load_use;
`else
  logic ex_raw, exmem_raw;
  logic unused_fwd;

  assign opa = rs_data_q;
  assign opb = rt_data_q;

  // Without bypass paths, any in-flight writer of a source register must stall ID.
  assign ex_raw    = valid_q && reg_write_q && (dst_addr != '0) &&
                     ((dst_addr == id_rs_addr_i) || (dst_addr == id_rt_addr_i));
  assign exmem_raw = exmem_reg_write_i && (exmem_rd_addr_i != '0) &&
                     ((exmem_rd_addr_i == id_rs_addr_i) || (exmem_rd_addr_i == id_rt_addr_i));
  assign hazard_o  = load_use || (id_valid_i && (ex_raw || exmem_raw));

  assign unused_fwd = ^{exmem_result_i, memwb_reg_write_i, memwb_rd_addr_i, memwb_data_i,
                        rs_addr_q, rt_addr_q};
`endif

  assign ex_valid_o      = valid_q;
  assign alu_src1_o      = opa;
  assign alu_src2_o      = alu_src_q ? imm_q : opb;
  assign ex_store_data_o = opb;
  assign ex_dst_addr_o   = dst_addr;
  assign alu_ctrl_o      = valid_q ? alu_ctrl_q : '0;
  assign ex_reg_write_o  = valid_q & reg_write_q;
  assign ex_mem_read_o   = valid_q & mem_read_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage; expectations follow the ID_EX_FWD_EN build option.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          stall_i, flush_i, id_valid_i;
  logic [DW-1:0] id_rs_data_i, id_rt_data_i, id_imm_i;
  logic [AW-1:0] id_rs_addr_i, id_rt_addr_i, id_rd_addr_i;
  logic [CW-1:0] id_alu_ctrl_i;
  logic          id_alu_src_i, id_reg_dst_i, id_reg_write_i, id_mem_read_i;
  logic          exmem_reg_write_i, memwb_reg_write_i;
  logic [AW-1:0] exmem_rd_addr_i, memwb_rd_addr_i;
  logic [DW-1:0] exmem_result_i, memwb_data_i;
  logic          ex_valid_o, ex_reg_write_o, ex_mem_read_o, hazard_o;
  logic [DW-1:0] alu_src1_o, alu_src2_o, ex_store_data_o;
  logic [CW-1:0] alu_ctrl_o;
  logic [AW-1:0] ex_dst_addr_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  id_ex_stage #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i),
    .id_imm_i(id_imm_i), .id_rs_addr_i(id_rs_addr_i), .id_rt_addr_i(id_rt_addr_i),
    .id_rd_addr_i(id_rd_addr_i), .id_alu_ctrl_i(id_alu_ctrl_i), .id_alu_src_i(id_alu_src_i),
    .id_reg_dst_i(id_reg_dst_i), .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i),
    .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_addr_i(exmem_rd_addr_i),
    .exmem_result_i(exmem_result_i), .memwb_reg_write_i(memwb_reg_write_i),
    .memwb_rd_addr_i(memwb_rd_addr_i), .memwb_data_i(memwb_data_i),
    .ex_valid_o(ex_valid_o), .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o),
    .alu_ctrl_o(alu_ctrl_o), .ex_store_data_o(ex_store_data_o), .ex_dst_addr_o(ex_dst_addr_o),
    .ex_reg_write_o(ex_reg_write_o), .ex_mem_read_o(ex_mem_read_o), .hazard_o(hazard_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [3:0] ctrl, input logic asrc,
                        input logic rdst, input logic rw, input logic mr);
    id_valid_i = v; id_rs_data_i = rsd; id_rt_data_i = rtd; id_imm_i = imm;
    id_rs_addr_i = rs; id_rt_addr_i = rt; id_rd_addr_i = rd; id_alu_ctrl_i = ctrl;
    id_alu_src_i = asrc; id_reg_dst_i = rdst; id_reg_write_i = rw; id_mem_read_i = mr;
  endtask

  initial begin
    rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    exmem_reg_write_i = 0; exmem_rd_addr_i = 0; exmem_result_i = 0;
    memwb_reg_write_i = 0; memwb_rd_addr_i = 0; memwb_data_i = 0;

    // Reset state
    step();
    check("rst_valid", 32'(ex_valid_o), 0);
    check("rst_ctrl",  32'(alu_ctrl_o), 0);
    check("rst_src1",  alu_src1_o, 0);
    check("rst_src2",  alu_src2_o, 0);
    check("rst_haz",   32'(hazard_o), 0);
    rst_i = 1'b1;

    // Basic capture, immediate as src2
    set_id(1, 32'd5, 32'd9, 32'd7, 5'd1, 5'd2, 5'd6, 4'b0010, 1, 1, 1, 0);
    step();
    id_valid_i = 0;
    check("cap_valid", 32'(ex_valid_o), 1);
    check("cap_src1",  alu_src1_o, 32'd5);
    check("cap_src2",  alu_src2_o, 32'd7);
    check("cap_ctrl",  32'(alu_ctrl_o), 32'b0010);
    check("cap_store", ex_store_data_o, 32'd9);
    check("cap_dst",   32'(ex_dst_addr_o), 32'd6);
    check("cap_rw",    32'(ex_reg_write_o), 1);
    check("cap_mr",    32'(ex_mem_read_o), 0);

    // Forwarding priority on rs=3, rt=2
    set_id(1, 32'h11, 32'h22, 32'h0, 5'd3, 5'd2, 5'd9, 4'b0001, 0, 0, 1, 0);
    step();
    id_valid_i = 0;
    check("fwd_dst_rt", 32'(ex_dst_addr_o), 32'd2);
    exmem_reg_write_i = 1; exmem_rd_addr_i = 3; exmem_result_i = 32'hAA;
    memwb_reg_write_i = 1; memwb_rd_addr_i = 3; memwb_data_i = 32'hBB;
    #1 check("fwd_exmem", alu_src1_o, FWD ? 32'hAA : 32'h11);
    exmem_reg_write_i = 0;
    #1 check("fwd_memwb", alu_src1_o, FWD ? 32'hBB : 32'h11);
    exmem_reg_write_i = 1; exmem_rd_addr_i = 0; memwb_rd_addr_i = 0;
    #1 check("fwd_r0", alu_src1_o, 32'h11);
    memwb_rd_addr_i = 2; memwb_data_i = 32'hCC;
    #1 check("fwd_b_src2",  alu_src2_o, FWD ? 32'hCC : 32'h22);
    check("fwd_b_store", ex_store_data_o, FWD ? 32'hCC : 32'h22);

    // EX/MEM writer of an ID source: stalls only when forwarding is absent
    memwb_reg_write_i = 0;
    exmem_rd_addr_i = 3;
    id_valid_i = 1; id_rs_addr_i = 3; id_rt_addr_i = 0;
    #1 check("nofwd_haz", 32'(hazard_o), FWD ? 0 : 1);
    exmem_reg_write_i = 0; exmem_rd_addr_i = 0; exmem_result_i = 0;

    // Load-use: lw $4 in EX
    set_id(1, 32'h100, 32'h0, 32'h8, 5'd1, 5'd4, 5'd0, 4'b0010, 1, 0, 1, 1);
    step();
    check("lw_mr",  32'(ex_mem_read_o), 1);
    check("lw_dst", 32'(ex_dst_addr_o), 32'd4);
    set_id(1, 32'h0, 32'h0, 32'h0, 5'd4, 5'd5, 5'd6, 4'b0110, 0, 1, 1, 0);
    #1 check("lu_rs_haz", 32'(hazard_o), 1);
    id_rs_addr_i = 7; id_rt_addr_i = 4; id_alu_src_i = 1;
    #1 check("lu_rt_imm_haz", 32'(hazard_o), FWD ? 0 : 1);
    id_alu_src_i = 0;
    #1 check("lu_rt_haz", 32'(hazard_o), 1);
    id_valid_i = 0;
    #1 check("lu_idinv_haz", 32'(hazard_o), 0);
    id_valid_i = 1; id_rs_addr_i = 4;
    flush_i = 1;
    step();
    flush_i = 0;
    check("flush_valid", 32'(ex_valid_o), 0);
    check("flush_rw",    32'(ex_reg_write_o), 0);
    check("flush_mr",    32'(ex_mem_read_o), 0);
    check("flush_ctrl",  32'(alu_ctrl_o), 0);
    check("flush_haz",   32'(hazard_o), 0);

    // Stall holds for three cycles while ID changes
    set_id(1, 32'h123, 32'h55, 32'h44, 5'd8, 5'd10, 5'd9, 4'b0110, 1, 1, 1, 0);
    step();
    stall_i = 1;
    set_id(1, 32'hFFFF_FFFF, 32'hEEEE_EEEE, 32'hDDDD, 5'd11, 5'd12, 5'd13, 4'b0111, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall%0d_src1", i), alu_src1_o, 32'h123);
      check($sformatf("stall%0d_src2", i), alu_src2_o, 32'h44);
      check($sformatf("stall%0d_ctrl", i), 32'(alu_ctrl_o), 32'b0110);
      check($sformatf("stall%0d_dst", i),  32'(ex_dst_addr_o), 32'd9);
    end
    flush_i = 1;
    step();
    stall_i = 0; flush_i = 0;
    check("stfl_valid", 32'(ex_valid_o), 0);
    check("stfl_ctrl",  32'(alu_ctrl_o), 0);
    check("stfl_src1",  alu_src1_o, 0);
    check("stfl_src2",  alu_src2_o, 0);

    // Invalid ID instruction gates controls
    set_id(0, 32'h9, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3, 4'b0010, 0, 1, 1, 1);
    step();
    check("inv_rw",   32'(ex_reg_write_o), 0);
    check("inv_mr",   32'(ex_mem_read_o), 0);
    check("inv_ctrl", 32'(alu_ctrl_o), 0);
    check("inv_src1", alu_src1_o, 32'h9);

    // Asynchronous reset mid-cycle
    set_id(1, 32'h77, 32'h66, 32'h0, 5'd1, 5'd2, 5'd3, 4'b1100, 0, 1, 1, 0);
    step();
    check("pre_rst_valid", 32'(ex_valid_o), 1);
    #2 rst_i = 1'b0;
    #1;
    check("arst_valid", 32'(ex_valid_o), 0);
    check("arst_ctrl",  32'(alu_ctrl_o), 0);
    check("arst_src1",  alu_src1_o, 0);
    check("arst_store", ex_store_data_o, 0);
    check("arst_dst",   32'(ex_dst_addr_o), 0);
    check("arst_rw",    32'(ex_reg_write_o), 0);
    rst_i = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register that sits directly upstream of the ALU.
- Captures the decoded operands and control fields each cycle.
- Resolves EX-stage operand forwarding from the EX/MEM and MEM/WB stages.
- Drives the ALU's src1/src2/ctrl inputs, and flags load-use hazards back to the hazard/PC logic.

Parameters:
- DW, 32, datapath width
- AW, 5, register address width
- CW, 4, ALU control width (0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt, 1100 nor)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-low reset
- stall_i  in  1  hold current EX contents
- flush_i  in  1  insert bubble
- id_valid_i  in  1  ID holds a real instruction
- id_rs_data_i  in  DW  register-file read A
- id_rt_data_i  in  DW  register-file read B
- id_imm_i  in  DW  sign-extended immediate
- id_rs_addr_i  in  AW  rs field
- id_rt_addr_i  in  AW  rt field
- id_rd_addr_i  in  AW  rd field
- id_alu_ctrl_i  in  CW  ALU operation
- id_alu_src_i  in  1  1 = immediate as src2
- id_reg_dst_i  in  1  1 = rd is destination, 0 = rt is destination
- id_reg_write_i  in  1  instruction writes the register file
- id_mem_read_i  in  1  instruction is a load
- exmem_reg_write_i  in  1  EX/MEM writes the register file
- exmem_rd_addr_i  in  AW  EX/MEM destination
- exmem_result_i  in  DW  EX/MEM ALU result
- memwb_reg_write_i  in  1  MEM/WB writes the register file
- memwb_rd_addr_i  in  AW  MEM/WB destination
- memwb_data_i  in  DW  MEM/WB writeback data
- ex_valid_o  out  1  EX holds a real instruction
- alu_src1_o  out  DW  ALU operand 1
- alu_src2_o  out  DW  ALU operand 2
- alu_ctrl_o  out  CW  ALU control
- ex_store_data_o  out  DW  forwarded rt value (store data)
- ex_dst_addr_o  out  AW  resolved destination register
- ex_reg_write_o  out  1  gated by ex_valid
- ex_mem_read_o  out  1  gated by ex_valid
- hazard_o  out  1  load-use stall request

Behaviour:
Reset
- rst_i low clears all EX registers to 0 immediately, asynchronously.
- Resulting outputs: ex_valid_o=0, alu_ctrl_o=0000, all data outputs=0, hazard_o=0.

Capture, on the rising edge, in priority order
- flush_i: load a bubble (valid=0, reg_write=0, mem_read=0, ctrl=0000); data fields are don't-care but cleared to 0. Flush overrides stall.
- Otherwise stall_i: hold all registers.
- Otherwise: load every id_* field; valid=id_valid_i.

Latency
- One cycle from the ID inputs to the EX outputs.
- Forwarding and the operand muxes are combinational on the registered fields.

Destination
- ex_dst_addr_o = reg_dst ? rd : rt.

Forwarding (operand A from rs, operand B from rt)
- EX/MEM source: selected if exmem_reg_write_i, exmem_rd_addr_i != 0, and exmem_rd_addr_i equals the operand's address.
- MEM/WB source: selected under the same conditions using memwb_*.
- Priority: EX/MEM over MEM/WB over the registered value.
- Register 0 is never forwarded.

Operand muxing
- alu_src1_o = forwarded A.
- ex_store_data_o = forwarded B.
- alu_src2_o = alu_src ? imm : forwarded B.

Hazard
- hazard_o = ex_valid & ex_mem_read & dst != 0 & (dst == id_rs_addr_i | (dst == id_rt_addr_i & !id_alu_src_i)) & id_valid_i.
- hazard_o is combinational.
- The controller answers hazard_o by stalling IF/ID and asserting flush_i here in the same cycle.

Invalid EX
- When ex_valid=0, ex_reg_write_o and ex_mem_read_o are forced to 0 and alu_ctrl_o is forced to 0000.

Optional Feature:
- Macro ID_EX_FWD_EN.
- Defined: forwarding logic as described above.
- Undefined: forwarding is removed, operands come straight from the registered register-file values, and hazard_o additionally asserts on any valid EX/MEM or EX writer matching rs or rt (nonzero), so the pipeline stalls instead of forwarding.

Decomposition:
- Shared package cpu_pkg holds:
  - ALU control encodings ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR
  - forwarding select encodings FWD_REG=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01
  - DW and AW defaults
- One sub-module, fwd_unit: combinational source-select per operand. It is instantiated twice (operand A, operand B).

Test Plan:
- Reset mid-run: drive valid traffic, pull rst_i low between edges -> outputs 0 immediately, ex_valid_o=0, alu_ctrl_o=0000.
- Capture: id_rs_data=5, id_imm=7, alu_src=1, ctrl=0010 -> next cycle src1=5, src2=7, ctrl=0010, valid=1.
- Forward priority: EX rs=3; exmem rd=3 result=0xAA; memwb rd=3 data=0xBB -> src1=0xAA. With exmem_reg_write=0 -> src1=0xBB. With rd=0 on both -> registered value.
- Load-use: EX holds lw to $4, ID uses rs=$4 -> hazard_o=1. Apply flush on the next edge -> ex_valid_o=0 and ex_reg_write_o=0.
- Stall vs flush: stall=1 holds all outputs for 3 cycles; stall=1 and flush=1 together -> bubble loaded.
- Feature off (ID_EX_FWD_EN undefined): exmem rd match on rs=3 -> src1 = registered value and hazard_o=1.
